// File: rtl/spart_pkg.sv
// Shared register-map and bit-index definitions for the SPART bus/FIFO interface.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'b00,
    ADDR_STAT = 2'b01,
    ADDR_DIVL = 2'b10,
    ADDR_DIVH = 2'b11
  } ioaddr_e;

  // Status register bit positions
  localparam int unsigned ST_RDA      = 0;
  localparam int unsigned ST_TBR      = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_TX_EMPTY = 3;
  localparam int unsigned ST_RX_OVR   = 4;
  localparam int unsigned ST_TX_OVF   = 5;

  // Control register bit positions
  localparam int unsigned CTL_FLUSH_TX = 0;
  localparam int unsigned CTL_FLUSH_RX = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head, flush, and push-while-full-with-pop support.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the same-cycle push needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/spart_bus_fifo_if.sv
// Processor bus front end for a SPART: TX/RX FIFOs, sticky status, flush control and baud divisor.
module spart_bus_fifo_if
  import spart_pkg::*;
#(
  parameter int unsigned           DATA_W     = 8,
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter logic [2*DATA_W-1:0]   BAUD_RST   = 16'd325
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iocs,
  input  logic                  iorw,
  input  logic [1:0]            ioaddr,
  inout  wire  [DATA_W-1:0]     databus,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic [2*DATA_W-1:0]   baud_div,
  output logic                  baud_load
);

  localparam int unsigned DIV_W = 2 * DATA_W;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  ioaddr_e             addr;
  logic                acc_rd, acc_wr;
  logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_drop;
  logic                rx_pop, rx_flush, rx_full, rx_empty, rx_drop;
  logic [CW-1:0]       tx_cnt, rx_cnt;
  logic [DATA_W-1:0]   rx_head, rd_data;
  logic                ctl_wr, stat_rd;

  logic                tx_ovf_q, tx_ovf_d;
  logic                rx_ovr_q, rx_ovr_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DIV_W-1:0]    baud_div_q, baud_div_d;
  logic                baud_load_q, baud_load_d;

  assign addr    = ioaddr_e'(ioaddr);
  assign acc_rd  = iocs && iorw;
  assign acc_wr  = iocs && !iorw;

  assign tx_push  = acc_wr && (addr == ADDR_DATA);
  assign ctl_wr   = acc_wr && (addr == ADDR_STAT);
  assign tx_flush = ctl_wr && databus[CTL_FLUSH_TX];
  assign rx_flush = ctl_wr && databus[CTL_FLUSH_RX];
  assign rx_pop   = acc_rd && (addr == ADDR_DATA);
  assign stat_rd  = acc_rd && (addr == ADDR_STAT);
  assign tx_pop   = tx_valid && tx_ready;

  // Overflow only when the write is truly lost: no same-cycle pop freed a slot and no flush discarded it.
  assign tx_drop = tx_push && tx_full && !tx_pop && !tx_flush;
  assign rx_drop = rx_valid && rx_full && !(rx_pop && !rx_empty) && !rx_flush;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .flush_i (tx_flush),
    .din_i   (databus),
    .head_o  (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_cnt)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_valid),
    .pop_i   (rx_pop),
    .flush_i (rx_flush),
    .din_i   (rx_data),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_cnt)
  );

  assign tx_valid  = !tx_empty;
  assign baud_div  = baud_div_q;
  assign baud_load = baud_load_q;

  always_comb begin
    rd_data = '0;
    unique case (addr)
      ADDR_DATA: rd_data = (rx_cnt == '0) ? '0 : rx_head;
      ADDR_STAT: begin
        rd_data[ST_RDA]      = !rx_empty;
        rd_data[ST_TBR]      = !tx_full;
        rd_data[ST_RX_FULL]  = rx_full;
        rd_data[ST_TX_EMPTY] = (tx_cnt == '0);
        rd_data[ST_RX_OVR]   = rx_ovr_q;
        rd_data[ST_TX_OVF]   = tx_ovf_q;
      end
      ADDR_DIVL: rd_data = baud_div_q[DATA_W-1:0];
      ADDR_DIVH: rd_data = baud_div_q[DIV_W-1:DATA_W];
      default:   rd_data = '0;
    endcase
  end

  assign databus = acc_rd ? rd_data : 'z;

  // Sticky set takes priority over the status-read clear.
  always_comb begin
    tx_ovf_d    = tx_drop || (tx_ovf_q && !stat_rd);
    rx_ovr_d    = rx_drop || (rx_ovr_q && !stat_rd);
    hold_d      = hold_q;
    baud_div_d  = baud_div_q;
    baud_load_d = 1'b0;
    if (acc_wr && (addr == ADDR_DIVL)) begin
      hold_d = databus;
    end
    if (acc_wr && (addr == ADDR_DIVH)) begin
      baud_div_d  = {databus, hold_q};
      baud_load_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf_q    <= 1'b0;
      rx_ovr_q    <= 1'b0;
      hold_q      <= '0;
      baud_div_q  <= BAUD_RST;
      baud_load_q <= 1'b0;
    end else begin
      tx_ovf_q    <= tx_ovf_d;
      rx_ovr_q    <= rx_ovr_d;
      hold_q      <= hold_d;
      baud_div_q  <= baud_div_d;
      baud_load_q <= baud_load_d;
    end
  end

endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Directed self-checking bench for spart_bus_fifo_if (DATA_W=8, FIFO_DEPTH=8).
module tb_spart_bus_fifo_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iocs = 1'b0;
  logic        iorw = 1'b0;
  logic [1:0]  ioaddr = 2'b00;
  wire  [7:0]  databus;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dout = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] baud_div;
  logic        baud_load;

  int checks = 0;
  int failures = 0;

  assign databus = tb_oe ? tb_dout : 8'hzz;

  always #5 clk = ~clk;

  spart_bus_fifo_if #(
    .DATA_W     (8),
    .FIFO_DEPTH (8),
    .BAUD_RST   (16'd325)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .baud_div  (baud_div),
    .baud_load (baud_load)
  );

  // All stimulus tasks are entered and left on a falling clock edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_oe = 1'b1; tb_dout = d;
    @(negedge clk);
    iocs = 1'b0; tb_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a; tb_oe = 1'b0;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++;
    if (baud_div !== 16'd325) begin failures++; $display("FAIL reset_baud_div got=%0d exp=325", baud_div); end
    checks++;
    if (baud_load !== 1'b0) begin failures++; $display("FAIL reset_baud_load got=%b exp=0", baud_load); end
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0A) begin failures++; $display("FAIL reset_status got=%h exp=0a", d); end
  endtask

  task automatic test_baud;
    logic [7:0] d;
    bus_write(2'b10, 8'h34);
    checks++;
    if (baud_div !== 16'd325 || baud_load !== 1'b0) begin
      failures++; $display("FAIL divl_no_commit got=%h/%b exp=0145/0", baud_div, baud_load);
    end
    bus_write(2'b11, 8'h12);
    checks++;
    if (baud_div !== 16'h1234 || baud_load !== 1'b1) begin
      failures++; $display("FAIL divh_commit got=%h/%b exp=1234/1", baud_div, baud_load);
    end
    @(negedge clk);
    checks++;
    if (baud_load !== 1'b0) begin failures++; $display("FAIL baud_load_single got=%b exp=0", baud_load); end
    bus_write(2'b10, 8'h45);
    bus_write(2'b11, 8'h01);
    checks++;
    if (baud_div !== 16'h0145 || baud_load !== 1'b1) begin
      failures++; $display("FAIL divh_commit2 got=%h/%b exp=0145/1", baud_div, baud_load);
    end
    bus_read(2'b10, d);
    checks++;
    if (d !== 8'h45) begin failures++; $display("FAIL read_divl got=%h exp=45", d); end
    bus_read(2'b11, d);
    checks++;
    if (d !== 8'h01) begin failures++; $display("FAIL read_divh got=%h exp=01", d); end
    bus_write(2'b10, 8'hFF);
    bus_read(2'b10, d);
    checks++;
    if (d !== 8'h45) begin failures++; $display("FAIL read_divl_committed got=%h exp=45", d); end
    bus_write(2'b11, 8'h01);
    checks++;
    if (baud_div !== 16'h01FF) begin failures++; $display("FAIL divh_commit3 got=%h exp=01ff", baud_div); end
  endtask

  task automatic test_tx_overflow;
    logic [7:0] d;
    logic [7:0] exp;
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      exp = 8'(i);
      bus_write(2'b00, exp);
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      failures++; $display("FAIL tx_head_after_fill got=%b/%h exp=1/01", tx_valid, tx_data);
    end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h20) begin failures++; $display("FAIL tx_full_status got=%h exp=20", d); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL tx_ovf_cleared got=%h exp=00", d); end
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp = 8'(i);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp) begin
        failures++; $display("FAIL tx_drain_%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_drained_valid got=%b exp=0", tx_valid); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0A) begin failures++; $display("FAIL tx_drained_status got=%h exp=0a", d); end
  endtask

  task automatic test_rx_basic;
    logic [7:0] d;
    rx_push(8'hA5);
    rx_push(8'h5A);
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0B) begin failures++; $display("FAIL rx_rda_status got=%h exp=0b", d); end
    bus_read(2'b00, d);
    checks++;
    if (d !== 8'hA5) begin failures++; $display("FAIL rx_read1 got=%h exp=a5", d); end
    bus_read(2'b00, d);
    checks++;
    if (d !== 8'h5A) begin failures++; $display("FAIL rx_read2 got=%h exp=5a", d); end
    bus_read(2'b00, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL rx_read_empty got=%h exp=00", d); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0A) begin failures++; $display("FAIL rx_empty_status got=%h exp=0a", d); end
  endtask

  task automatic test_rx_full;
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      exp = 8'h10 + 8'(i);
      rx_push(exp);
    end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0F) begin failures++; $display("FAIL rx_full_status got=%h exp=0f", d); end
    // overflow push coincident with a status read: the sticky bit must survive
    rx_valid = 1'b1; rx_data = 8'hEE;
    bus_read(2'b01, d);
    rx_valid = 1'b0;
    checks++;
    if (d !== 8'h0F) begin failures++; $display("FAIL rx_ovr_same_cycle_read got=%h exp=0f", d); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h1F) begin failures++; $display("FAIL rx_ovr_set_wins got=%h exp=1f", d); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0F) begin failures++; $display("FAIL rx_ovr_cleared got=%h exp=0f", d); end
    rx_valid = 1'b1; rx_data = 8'h99;
    bus_read(2'b00, d);
    rx_valid = 1'b0;
    checks++;
    if (d !== 8'h10) begin failures++; $display("FAIL rx_full_push_pop_head got=%h exp=10", d); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0F) begin failures++; $display("FAIL rx_full_push_pop_status got=%h exp=0f", d); end
    for (int i = 1; i <= 8; i++) begin
      exp = (i == 8) ? 8'h99 : (8'h10 + 8'(i));
      bus_read(2'b00, d);
      checks++;
      if (d !== exp) begin failures++; $display("FAIL rx_full_drain_%0d got=%h exp=%h", i, d, exp); end
    end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0A) begin failures++; $display("FAIL rx_full_drained_status got=%h exp=0a", d); end
  endtask

  task automatic test_flush;
    logic [7:0] d;
    tx_ready = 1'b0;
    bus_write(2'b00, 8'hC1);
    bus_write(2'b00, 8'hC2);
    rx_push(8'hD1);
    rx_push(8'hD2);
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h03) begin failures++; $display("FAIL pre_flush_status got=%h exp=03", d); end
    rx_valid = 1'b1; rx_data = 8'h77;
    bus_write(2'b01, 8'h03);
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL flush_tx_valid got=%b exp=0", tx_valid); end
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0A) begin failures++; $display("FAIL flush_status got=%h exp=0a", d); end
    bus_read(2'b00, d);
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL flush_rx_data got=%h exp=00", d); end
  endtask

  task automatic test_no_cs;
    logic [7:0] d;
    rx_push(8'h3C);
    iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
    @(negedge clk);
    iorw = 1'b0; tb_oe = 1'b1; tb_dout = 8'h55;
    @(negedge clk);
    tb_oe = 1'b0;
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL no_cs_write got=%b exp=0", tx_valid); end
    bus_read(2'b00, d);
    checks++;
    if (d !== 8'h3C) begin failures++; $display("FAIL no_cs_read got=%h exp=3c", d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    bus_write(2'b00, 8'hE1);
    bus_write(2'b10, 8'hAB);
    rx_push(8'h42);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || baud_div !== 16'd325) begin
      failures++; $display("FAIL async_reset got=%b/%h exp=0/0145", tx_valid, baud_div);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'b01, d);
    checks++;
    if (d !== 8'h0A) begin failures++; $display("FAIL reset_mid_status got=%h exp=0a", d); end
    bus_write(2'b11, 8'h00);
    checks++;
    if (baud_div !== 16'h0000 || baud_load !== 1'b1) begin
      failures++; $display("FAIL reset_mid_holding got=%h/%b exp=0000/1", baud_div, baud_load);
    end
  endtask

  initial begin
    test_reset;
    test_baud;
    test_tx_overflow;
    test_rx_basic;
    test_rx_full;
    test_flush;
    test_no_cs;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
